lvds_mem_stream_reader: RTL and testbench

Avalon-MM read master that fetches a block of 32-bit words from the on-chip RAM (single-port, 8192 x 32, fixed one-cycle read latency) and presents them as a valid/ready word stream to the LVDS transmit serializer. It is the consumer end of the memory's s1 slave port: software or the echo controller loads a base address and word count, pulses start, and the block drains the region into the link. Flow control comes from the transmitter's ready, and there is no read-data loss under backpressure.

---
 rtl/lvds_mem_pkg.sv | 12 +
 rtl/lvds_word_fifo.sv | 50 +++++
 rtl/lvds_mem_stream_reader.sv | 126 ++++++++++++
 tb/tb_lvds_mem_stream_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_mem_pkg.sv
// Shared types and defaults for the RAM-to-LVDS stream reader.
package lvds_mem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam logic [3:0] BYTEEN_ALL = 4'hF;
endpackage

// File: rtl/lvds_word_fifo.sv
// Word FIFO with a registered head; a push into an empty FIFO is visible next cycle.
// Caller must never push when full (the read master's credit rule guarantees this).
module lvds_word_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [CNT_W-1:0]  count_n;
  logic              do_pop;

  assign do_pop   = pop & head_valid;
  assign rd_ptr_n = rd_ptr + PTR_W'(do_pop);
  assign count_n  = count + CNT_W'(push) - CNT_W'(do_pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      head_valid <= (count_n != '0);
      // The next head is the incoming word only when it lands in the head slot.
      if (count_n != '0)
        head_data <= (push && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
    end
  end
endmodule

// File: rtl/lvds_mem_stream_reader.sv
// Avalon-MM read master draining a RAM region into a valid/ready word stream.
// First word 2+READ_LATENCY cycles after start; reads stall on FIFO credits so no data is lost.
module lvds_mem_stream_reader
  import lvds_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                  state;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W:0]         remaining;
  logic [ADDR_W:0]         remaining_n;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W-1:0]        inflight_n;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        count_n;
  logic [CNT_W:0]          credit_used;
  logic [READ_LATENCY-1:0] ret_sr;
  logic                    accept;
  logic                    ret;
  logic                    pop;
  logic                    hold;
  logic                    has_credit;

  assign accept      = avm_read & ~avm_waitrequest;
  assign hold        = avm_read & avm_waitrequest;
  assign ret         = ret_sr[READ_LATENCY-1];
  assign pop         = tx_valid & tx_ready;
  assign remaining_n = remaining - (ADDR_W+1)'(accept);
  assign inflight_n  = inflight + CNT_W'(accept) - CNT_W'(ret);
  assign count_n     = fifo_count + CNT_W'(ret) - CNT_W'(pop);
  // Every issued read owns a FIFO slot until it is popped downstream.
  assign credit_used = {1'b0, count_n} + {1'b0, inflight_n};
  assign has_credit  = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  assign avm_address    = addr_q;
  assign avm_chipselect = avm_read;
  assign avm_byteenable = BYTEEN_ALL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      inflight  <= '0;
      ret_sr    <= '0;
      avm_read  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= inflight_n;
      ret_sr   <= (ret_sr << 1) | READ_LATENCY'(accept);
      case (state)
        IDLE: begin
          avm_read <= 1'b0;
          if (start) begin
            addr_q    <= base_addr;
            remaining <= length;
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              avm_read <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) addr_q <= addr_q + ADDR_W'(1);
          remaining <= remaining_n;
          if (remaining_n == '0) begin
            state    <= DRAIN;
            avm_read <= 1'b0;
          end else begin
            avm_read <= hold | has_credit;
          end
        end
        DRAIN: begin
          avm_read <= 1'b0;
          if (pop && (fifo_count == CNT_W'(1)) && (inflight == '0)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  lvds_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (ret),
    .push_data  (avm_readdata),
    .pop        (pop),
    .head_data  (tx_data),
    .head_valid (tx_valid),
    .count      (fifo_count)
  );
endmodule

// File: tb/tb_lvds_mem_stream_reader.sv
// Bench for lvds_mem_stream_reader: RAM model, scoreboard of expected words, scenario tasks.
module tb_lvds_mem_stream_reader;
  logic        clk;
  logic        reset_n;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] length;
  logic        busy;
  logic        done;
  logic [12:0] avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [31:0] ram [8192];
  logic [31:0] sb [$];
  logic [31:0] exp_word;
  int          n_checks;
  int          n_pass;

  lvds_mem_stream_reader #(
    .ADDR_W(13), .DATA_W(32), .READ_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency RAM; garbage outside the return cycle exposes mistimed captures.
  always @(posedge clk)
    avm_readdata <= (avm_read && !avm_waitrequest) ? ram[avm_address] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (reset_n && tx_valid && tx_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_extra_word got %08h required none", tx_data);
      end else begin
        exp_word = sb.pop_front();
        if (tx_data !== exp_word) $display("FAIL sb_word got %08h required %08h", tx_data, exp_word);
        else n_pass++;
      end
    end
  end

  task automatic launch(input logic [12:0] b, input logic [13:0] n);
    @(posedge clk); #1;
    base_addr = b;
    length    = n;
    start     = 1'b1;
    for (int i = 0; i < int'(n); i++) sb.push_back(32'((int'(b) + i) % 8192));
  endtask

  task automatic step();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({busy, done, avm_read, avm_chipselect, tx_valid} !== 5'b0)
      $display("FAIL reset_ctrl got %05b required 00000", {busy, done, avm_read, avm_chipselect, tx_valid});
    else n_pass++;
    n_checks++;
    if (avm_address !== 13'h0) $display("FAIL reset_addr got %h required 0", avm_address); else n_pass++;
    n_checks++;
    if (tx_data !== 32'h0) $display("FAIL reset_tx_data got %h required 0", tx_data); else n_pass++;
    n_checks++;
    if (avm_byteenable !== 4'hF) $display("FAIL byteenable got %h required f", avm_byteenable); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int first_v, last_v, done_c, done_n, busy_low;
    first_v = -1; last_v = -1; done_c = -1; done_n = 0; busy_low = 0;
    tx_ready = 1'b1;
    launch(13'h0010, 14'd8);
    for (int k = 1; k <= 14; k++) begin
      step();
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if ({busy, avm_read, avm_chipselect} !== 3'b111)
          $display("FAIL basic_first_read got %03b required 111", {busy, avm_read, avm_chipselect});
        else n_pass++;
        n_checks++;
        if (avm_address !== 13'h0010) $display("FAIL basic_first_addr got %h required 0010", avm_address);
        else n_pass++;
      end
      if (tx_valid && tx_ready) begin
        if (first_v < 0) first_v = k;
        last_v = k;
      end
      if (done) begin done_n++; done_c = k; end
      if (k <= 10 && !busy) busy_low++;
      if (k == 11) begin
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_after got %b required 0", busy); else n_pass++;
      end
    end
    n_checks++;
    if (first_v != 3) $display("FAIL basic_first_valid got %0d required 3", first_v); else n_pass++;
    n_checks++;
    if (last_v != 10) $display("FAIL basic_last_valid got %0d required 10", last_v); else n_pass++;
    n_checks++;
    if (done_n != 1 || done_c != 11)
      $display("FAIL basic_done got %0d pulses at %0d required 1 at 11", done_n, done_c);
    else n_pass++;
    n_checks++;
    if (busy_low != 0) $display("FAIL basic_busy_gap got %0d required 0", busy_low); else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL basic_sb_left got %0d required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [12:0] got [$];
    logic [12:0] exp_a [4];
    int done_n;
    exp_a = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    done_n = 0;
    launch(13'h1FFE, 14'd4);
    for (int k = 1; k <= 12; k++) begin
      step();
      @(negedge clk);
      if (avm_read && !avm_waitrequest) got.push_back(avm_address);
      if (done) done_n++;
    end
    n_checks++;
    if (got.size() != 4) $display("FAIL wrap_reads got %0d required 4", got.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got.size()) $display("FAIL wrap_addr%0d got none required %h", i, exp_a[i]);
      else if (got[i] !== exp_a[i]) $display("FAIL wrap_addr%0d got %h required %h", i, got[i], exp_a[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_n != 1 || sb.size() != 0)
      $display("FAIL wrap_done got %0d pulses %0d left required 1 pulse 0 left", done_n, sb.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc, hs, max_out, stall, done_n;
    acc = 0; hs = 0; max_out = 0; stall = 0; done_n = 0;
    launch(13'h0100, 14'd16);
    for (int k = 1; k <= 120; k++) begin
      step();
      if (k < 40) tx_ready = (k % 4 == 0) || (k % 4 == 3);
      else if (k < 80) tx_ready = 1'($urandom_range(0, 1));
      else tx_ready = 1'b1;
      @(negedge clk);
      if (busy && acc < 16 && !avm_read) stall++;
      if (avm_read && !avm_waitrequest) acc++;
      if (tx_valid && tx_ready) hs++;
      if (acc - hs > max_out) max_out = acc - hs;
      if (done) done_n++;
    end
    tx_ready = 1'b1;
    n_checks++;
    if (max_out > 4) $display("FAIL bp_outstanding got %0d required <=4", max_out); else n_pass++;
    n_checks++;
    if (stall == 0) $display("FAIL bp_credit_stall got %0d required >0", stall); else n_pass++;
    n_checks++;
    if (acc != 16 || hs != 16) $display("FAIL bp_counts got %0d reads %0d words required 16/16", acc, hs);
    else n_pass++;
    n_checks++;
    if (done_n != 1 || sb.size() != 0)
      $display("FAIL bp_done got %0d pulses %0d left required 1 pulse 0 left", done_n, sb.size());
    else n_pass++;
  endtask

  task automatic test_zero_and_ignored();
    int rd_seen, acc, in_rng, done_n;
    rd_seen = 0; acc = 0; in_rng = 0; done_n = 0;
    launch(13'h0050, 14'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      @(negedge clk);
      if (avm_read) rd_seen++;
      if (k == 1) begin
        n_checks++;
        if ({done, busy} !== 2'b10) $display("FAIL zero_done got done=%b busy=%b required 1 0", done, busy);
        else n_pass++;
      end
      if (k == 2) begin
        n_checks++;
        if (done !== 1'b0) $display("FAIL zero_done_width got %b required 0", done); else n_pass++;
      end
    end
    n_checks++;
    if (rd_seen != 0) $display("FAIL zero_reads got %0d required 0", rd_seen); else n_pass++;
    launch(13'h0200, 14'd6);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 3) begin start = 1'b1; base_addr = 13'h0300; length = 14'd2; end
      @(negedge clk);
      if (avm_read && !avm_waitrequest) begin
        acc++;
        if (avm_address >= 13'h0200 && avm_address <= 13'h0205) in_rng++;
      end
      if (done) done_n++;
    end
    n_checks++;
    if (acc != 6 || in_rng != 6) $display("FAIL ignored_reads got %0d (%0d in range) required 6", acc, in_rng);
    else n_pass++;
    n_checks++;
    if (done_n != 1 || sb.size() != 0)
      $display("FAIL ignored_done got %0d pulses %0d left required 1 pulse 0 left", done_n, sb.size());
    else n_pass++;
  endtask

  task automatic test_waitrequest();
    logic [12:0] got [$];
    int held, done_n;
    held = 0; done_n = 0;
    launch(13'h0040, 14'd6);
    for (int k = 1; k <= 20; k++) begin
      step();
      avm_waitrequest = (k >= 2 && k <= 4);
      @(negedge clk);
      if (k >= 2 && k <= 4 && avm_read && avm_address == 13'h0041) held++;
      if (avm_read && !avm_waitrequest) got.push_back(avm_address);
      if (done) done_n++;
    end
    avm_waitrequest = 1'b0;
    n_checks++;
    if (held != 3) $display("FAIL wait_hold got %0d required 3", held); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= got.size()) $display("FAIL wait_addr%0d got none required %h", i, 13'(13'h0040 + i));
      else if (got[i] !== 13'(13'h0040 + i))
        $display("FAIL wait_addr%0d got %h required %h", i, got[i], 13'(13'h0040 + i));
      else n_pass++;
    end
    n_checks++;
    if (done_n != 1 || sb.size() != 0)
      $display("FAIL wait_done got %0d pulses %0d left required 1 pulse 0 left", done_n, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int hs, done_n;
    hs = 0; done_n = 0;
    tx_ready = 1'b1;
    launch(13'h0500, 14'd20);
    for (int k = 1; k <= 40 && hs < 5; k++) begin
      step();
      @(negedge clk);
      if (tx_valid && tx_ready) hs++;
    end
    n_checks++;
    if (hs != 5) $display("FAIL rstmid_pre_words got %0d required 5", hs); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    sb.delete();
    n_checks++;
    if ({busy, done, avm_read, avm_chipselect, tx_valid} !== 5'b0)
      $display("FAIL rstmid_ctrl got %05b required 00000", {busy, done, avm_read, avm_chipselect, tx_valid});
    else n_pass++;
    n_checks++;
    if (avm_address !== 13'h0 || tx_data !== 32'h0)
      $display("FAIL rstmid_data got addr=%h data=%h required 0 0", avm_address, tx_data);
    else n_pass++;
    step(); step();
    @(posedge clk); #1;
    reset_n = 1'b1;
    hs = 0;
    launch(13'h0600, 14'd2);
    for (int k = 1; k <= 15; k++) begin
      step();
      @(negedge clk);
      if (tx_valid && tx_ready) hs++;
      if (done) done_n++;
    end
    n_checks++;
    if (hs != 2) $display("FAIL rstmid_post_words got %0d required 2", hs); else n_pass++;
    n_checks++;
    if (done_n != 1 || sb.size() != 0)
      $display("FAIL rstmid_done got %0d pulses %0d left required 1 pulse 0 left", done_n, sb.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    tx_ready = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 8192; i++) ram[i] = 32'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_ignored();
    test_waitrequest();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
